// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core
// Optional retired-instruction counter is built when CORE_SEQ_RETIRE_CNT_EN is defined.
module core_seq_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] PC_RESET    = '0,
    parameter int unsigned     MEM_TIMEOUT = 16,
    parameter int unsigned     RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr_o,
    output logic [XLEN-1:0]     pc_o,
    input  logic [XLEN-1:0]     next_pc_i,
    input  logic                regwrite_i,
    input  logic                memread_i,
    input  logic                memwrite_i,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                reg_we_o,
    input  logic                halt_i,
    output logic                halted_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic [RETIRE_W-1:0] retire_cnt_o
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int unsigned     WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [2:0]        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              timeout_hit;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17: legal_op = 1'b1;
            default:                    legal_op = 1'b0;
        endcase
    endfunction

    // The final wait cycle still succeeds if ready arrives in it.
    assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_d     = '0;
        err_code_d = err_code_q;
        case (state_q)
            S_RESET:  state_d = halt_i ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b01;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal_op(instr_q[6:0])) begin
                    state_d = S_EXEC;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = 2'b11;
                end
            end
            S_EXEC:   state_d = (memread_i | memwrite_i) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    if (memwrite_i) begin
                        pc_d    = next_pc_i;
                        state_d = halt_i ? S_HALT : S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                pc_d    = next_pc_i;
                state_d = halt_i ? S_HALT : S_FETCH;
            end
            S_HALT:   state_d = halt_i ? S_HALT : S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            pc_q       <= PC_RESET;
            instr_q    <= 32'h0000_0013;
            wait_q     <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_q     <= wait_d;
            err_code_q <= err_code_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && memwrite_i;
    assign reg_we_o   = (state_q == S_WB) && regwrite_i;
    assign halted_o   = (state_q == S_HALT);
    assign err_o      = (state_q == S_ERR);
    assign err_code_o = err_code_q;

`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic                retire;
    logic [RETIRE_W-1:0] retire_cnt_q;

    // Same edges that load the PC: leaving WB, or completing a store.
    assign retire = (state_q == S_WB) || ((state_q == S_MEM) && dmem_ready && memwrite_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;

    localparam int          TO     = 16;
    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, reg_we_o;
    logic [31:0] imem_addr, imem_rdata, instr_o, pc_o, next_pc_i, retire_cnt_o;
    logic        regwrite_i, memread_i, memwrite_i, halt_i, halted_o, err_o;
    logic [1:0]  err_code_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;
    logic [31:0] model_ret;
    logic [31:0] rnd, npc;
    logic [6:0]  op;
    int          iw, dw, k, bad;
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    core_seq_ctrl #(.XLEN(32), .PC_RESET(PC_RST), .MEM_TIMEOUT(TO), .RETIRE_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_o(instr_o), .pc_o(pc_o), .next_pc_i(next_pc_i),
        .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .reg_we_o(reg_we_o), .halt_i(halt_i), .halted_o(halted_o),
        .err_o(err_o), .err_code_o(err_code_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    function automatic bit writes_rd(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Decode stage stand-in driven from the instruction register
    always_comb begin
        memread_i  = (instr_o[6:0] == 7'h03);
        memwrite_i = (instr_o[6:0] == 7'h23);
        regwrite_i = writes_rd(instr_o[6:0]);
    end

    function automatic logic [31:0] exp_ret();
`ifdef CORE_SEQ_RETIRE_CNT_EN
        return model_ret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; halt_i = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc_o, PC_RST);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_outs", {imem_req, dmem_req, dmem_we, reg_we_o, halted_o, err_o, err_code_o}, 0);
        check("rst_retire", retire_cnt_o, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_first_req", {imem_req, imem_addr}, {1'b1, PC_RST});
        model_pc  = PC_RST;
        model_ret = 0;
    endtask

    // One instruction from its first FETCH cycle to the next FETCH, HALT or ERR.
    task automatic run_instr(input logic [31:0] ins, input int iwt, input int dwt,
                             input logic [31:0] nxt, input bit halt_exec, input string tag);
        int  cyc, n_ireq, n_dreq, n_rwe, n_dwe, rwe_at, n_post, bad_addr;
        int  exp_cyc, exp_ireq, exp_dreq;
        bit  left_fetch, is_mem, is_st, exp_err;
        logic [1:0] exp_code;
        cyc = 0; n_ireq = 0; n_dreq = 0; n_rwe = 0; n_dwe = 0; rwe_at = 0; n_post = 0;
        bad_addr = 0; left_fetch = 0;
        imem_rdata = ins;
        next_pc_i  = nxt;
        while (!(halted_o || err_o || (left_fetch && imem_req))) begin
            if (cyc >= 400) begin
                n_assert++; n_fail++;
                $display("FAIL %s_bound: observed %0d cycles required completion", tag, cyc);
                break;
            end
            if (!imem_req) left_fetch = 1;
            else if (imem_addr !== model_pc) bad_addr++;
            cyc++;
            if (imem_req) n_ireq++;
            if (dmem_req) n_dreq++;
            if (dmem_we) n_dwe++;
            if (reg_we_o) begin n_rwe++; rwe_at = cyc; end
            if (left_fetch) n_post++;
            if (halt_exec && n_post == 2) halt_i = 1'b1;
            imem_ready = imem_req ? (n_ireq == iwt + 1) : 1'($urandom_range(0, 1));
            dmem_ready = dmem_req ? (n_dreq == dwt + 1) : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        is_st  = (ins[6:0] == 7'h23);
        is_mem = is_st || (ins[6:0] == 7'h03);
        exp_err = 1; exp_code = 2'b00; exp_dreq = 0;
        exp_ireq = (iwt >= TO) ? TO : iwt + 1;
        if (iwt >= TO) begin
            exp_code = 2'b01; exp_cyc = TO;
        end else if (!is_legal(ins[6:0])) begin
            exp_code = 2'b11; exp_cyc = iwt + 2;
        end else if (is_mem && dwt >= TO) begin
            exp_code = 2'b10; exp_cyc = iwt + 3 + TO; exp_dreq = TO;
        end else begin
            exp_err  = 0;
            exp_dreq = is_mem ? dwt + 1 : 0;
            exp_cyc  = iwt + 3 + exp_dreq + (is_st ? 0 : 1);
        end
        if (!exp_err) begin
            model_pc  = nxt;
            model_ret = model_ret + 1;
        end
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_ireq"}, n_ireq, exp_ireq);
        check({tag, "_iaddr"}, bad_addr, 0);
        check({tag, "_dreq"}, n_dreq, exp_dreq);
        check({tag, "_dwe"}, n_dwe, is_st ? exp_dreq : 0);
        check({tag, "_rwe"}, {n_rwe, rwe_at},
              (!exp_err && writes_rd(ins[6:0])) ? {32'd1, exp_cyc} : 64'd0);
        check({tag, "_err"}, {err_o, err_code_o}, {exp_err, exp_code});
        check({tag, "_halted"}, halted_o, halt_exec && !exp_err);
        check({tag, "_pc"}, pc_o, model_pc);
        check({tag, "_retire"}, retire_cnt_o, exp_ret());
    endtask

    task automatic err_hold(input int n, input logic [1:0] code, input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem_req || dmem_req || dmem_we || reg_we_o || !err_o || err_code_o !== code) nbad++;
        end
        check({tag, "_sticky"}, nbad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; halt_i = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = 32'h0; next_pc_i = 32'h0;
        do_reset();

        run_instr(32'h0050_0093, 0, 0, 32'h4, 1'b0, "addi");
        run_instr(32'h0020_81B3, 0, 0, 32'h8, 1'b1, "add_halt");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!halted_o || imem_req || dmem_req || pc_o !== 32'h8) bad++;
        end
        check("halt_hold", bad, 0);
        halt_i = 1'b0;
        @(negedge clk);
        check("halt_release", {halted_o, imem_req, imem_addr}, {1'b0, 1'b1, 32'h8});

        run_instr(32'h0000_2103, 0, 3, 32'hC, 1'b0, "lw_wait3");
        run_instr(32'h0020_2023, 0, 0, 32'h10, 1'b0, "sw");
        run_instr(32'h0000_2103, 15, 15, 32'h14, 1'b0, "lw_edge");
        run_instr(32'h0020_2023, 2, 15, 32'h18, 1'b0, "sw_edge");

        for (int i = 0; i < 30; i++) begin
            rnd = $urandom;
            op  = ops[$urandom_range(0, 8)];
            iw  = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) dw = 15;
            npc = $urandom;
            npc[1:0] = 2'b00;
            run_instr({rnd[31:7], op}, iw, dw, npc, 1'b0, "rand");
        end

        run_instr(32'h0000_007F, 1, 0, 32'h0, 1'b0, "illegal");
        err_hold(20, 2'b11, "illegal");
        do_reset();

        run_instr(32'h0050_0093, 1000, 0, 32'h4, 1'b0, "itimeout");
        err_hold(20, 2'b01, "itimeout");
        do_reset();

        run_instr(32'h0050_0093, 0, 0, 32'h4, 1'b0, "addi2");
        run_instr(32'h0000_2103, 1, 50, 32'h8, 1'b0, "dtimeout");
        err_hold(20, 2'b10, "dtimeout");
        do_reset();

        run_instr(32'h0050_0093, 0, 0, 32'h4, 1'b0, "addi3");
        imem_rdata = 32'h0000_2103;
        next_pc_i  = 32'h40;
        k = 0;
        while (!dmem_req && k < 20) begin
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            @(negedge clk);
            k++;
        end
        check("midrst_in_mem", dmem_req, 1'b1);
        reset = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        check("midrst_reqs", {imem_req, dmem_req, dmem_we, reg_we_o}, 0);
        check("midrst_pc", pc_o, PC_RST);
        check("midrst_retire", retire_cnt_o, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_refetch", {imem_req, imem_addr}, {1'b1, PC_RST});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
